// File: rtl/tank_controller.sv
// -----------------------------------------------------------------------------
// tank_controller
//   Converts debounced joystick and fire levels into a tank grid position and
//   direction, plus a single in-flight bullet. Tank and bullet each advance on
//   their own tick divider. An update is committed only in a cycle where the
//   VGA block is not scanning, so a frame never sees a torn position.
//
// Ports
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   i_top_state[1:0]    top-level game state; play advances only in PLAY_STATE
//   i_VGA_buzy          1 = VGA is in the visible area; commits are deferred
//   i_up/down/left/right joystick levels, active-high
//   i_fire              fire button level, active-high (rising edge fires)
//   o_tank_x/y[5:0]     tank cell
//   o_tank_dir[1:0]     0=up 1=right 2=down 3=left
//   o_bullet_valid      bullet in flight
//   o_bullet_x/y[5:0]   bullet cell (hold the last value once the bullet dies)
//   o_bullet_dir[1:0]   bullet travel direction
// -----------------------------------------------------------------------------
module tank_controller #(
   parameter int         GRID_W     = 40,
   parameter int         GRID_H     = 30,
   parameter int         INIT_X     = 2,
   parameter int         INIT_Y     = 2,
   parameter int         INIT_DIR   = 0,
   parameter int         MOVE_DIV   = 3_125_000,
   parameter int         BULLET_DIV = 781_250,
   parameter logic [1:0] PLAY_STATE = 2'b01
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_top_state,
   input  logic       i_VGA_buzy,
   input  logic       i_up,
   input  logic       i_down,
   input  logic       i_left,
   input  logic       i_right,
   input  logic       i_fire,
   output logic [5:0] o_tank_x,
   output logic [5:0] o_tank_y,
   output logic [1:0] o_tank_dir,
   output logic       o_bullet_valid,
   output logic [5:0] o_bullet_x,
   output logic [5:0] o_bullet_y,
   output logic [1:0] o_bullet_dir
);

   localparam int MW = (MOVE_DIV   > 1) ? $clog2(MOVE_DIV)   : 1;
   localparam int BW = (BULLET_DIV > 1) ? $clog2(BULLET_DIV) : 1;
   localparam logic [MW-1:0] MOVE_LAST   = MW'(MOVE_DIV - 1);
   localparam logic [BW-1:0] BULLET_LAST = BW'(BULLET_DIV - 1);
   localparam logic [5:0]    X_MAX       = 6'(GRID_W - 1);
   localparam logic [5:0]    Y_MAX       = 6'(GRID_H - 1);

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   typedef enum logic {T_HOLD, T_RUN} tank_state_t;
   typedef enum logic {B_IDLE, B_FLY} bullet_state_t;

   // Neighbour cell in a direction; ok=0 when the step would leave the grid.
   // Bounds are tested on the current value so 6-bit wrap can never occur.
   typedef struct packed {
      logic       ok;
      logic [5:0] x;
      logic [5:0] y;
   } cell_t;

   function automatic cell_t step_cell(input logic [5:0] x, input logic [5:0] y,
                                       input logic [1:0] dir);
      cell_t c;
      c.ok = 1'b0;
      c.x  = x;
      c.y  = y;
      case (dir)
         DIR_UP:    if (y != 6'd0) begin c.ok = 1'b1; c.y = y - 6'd1; end
         DIR_RIGHT: if (x <  X_MAX) begin c.ok = 1'b1; c.x = x + 6'd1; end
         DIR_DOWN:  if (y <  Y_MAX) begin c.ok = 1'b1; c.y = y + 6'd1; end
         default:   if (x != 6'd0) begin c.ok = 1'b1; c.x = x - 6'd1; end
      endcase
      return c;
   endfunction

   // State registers
   tank_state_t   t_state,  t_state_d;
   bullet_state_t b_state,  b_state_d;
   logic [MW-1:0] move_cnt, move_cnt_d;
   logic [BW-1:0] bul_cnt,  bul_cnt_d;
   logic          move_pend, move_pend_d;
   logic          bul_pend,  bul_pend_d;
   logic          fire_q;
   logic          fire_req,  fire_req_d;
   logic [5:0]    tank_x, tank_x_d, tank_y, tank_y_d;
   logic [1:0]    tank_dir, tank_dir_d;
   logic [5:0]    bul_x, bul_x_d, bul_y, bul_y_d;
   logic [1:0]    bul_dir, bul_dir_d;

   // Combinational helpers
   logic       play, run;
   logic       move_tick, bul_tick;
   logic       move_commit, bul_commit, fire_commit;
   logic       fire_rise;
   logic       req_vld;
   logic [1:0] req_dir;
   cell_t      tank_nxt, bul_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_state   <= T_HOLD;
         b_state   <= B_IDLE;
         move_cnt  <= '0;
         bul_cnt   <= '0;
         move_pend <= 1'b0;
         bul_pend  <= 1'b0;
         fire_q    <= 1'b0;
         fire_req  <= 1'b0;
         tank_x    <= 6'(INIT_X);
         tank_y    <= 6'(INIT_Y);
         tank_dir  <= 2'(INIT_DIR);
         bul_x     <= '0;
         bul_y     <= '0;
         bul_dir   <= '0;
      end else begin
         t_state   <= t_state_d;
         b_state   <= b_state_d;
         move_cnt  <= move_cnt_d;
         bul_cnt   <= bul_cnt_d;
         move_pend <= move_pend_d;
         bul_pend  <= bul_pend_d;
         fire_q    <= i_fire;
         fire_req  <= fire_req_d;
         tank_x    <= tank_x_d;
         tank_y    <= tank_y_d;
         tank_dir  <= tank_dir_d;
         bul_x     <= bul_x_d;
         bul_y     <= bul_y_d;
         bul_dir   <= bul_dir_d;
      end
   end

   always_comb begin
      play      = (i_top_state == PLAY_STATE);
      t_state_d = play ? T_RUN : T_HOLD;
      // Entering play spends one cycle in HOLD; nothing can be pending then
      // because flags only set while already in play.
      run       = play && (t_state == T_RUN);

      move_tick = play && (move_cnt == MOVE_LAST);
      bul_tick  = play && (bul_cnt  == BULLET_LAST);
      fire_rise = i_fire && !fire_q;

      move_commit = run && move_pend && !i_VGA_buzy;
      bul_commit  = run && bul_pend  && !i_VGA_buzy;
      fire_commit = run && fire_req  && !i_VGA_buzy;

      // Dividers restart from 0 whenever play resumes; flags are one-deep.
      move_cnt_d  = (!play || move_tick) ? '0 : move_cnt + MW'(1);
      bul_cnt_d   = (!play || bul_tick)  ? '0 : bul_cnt  + BW'(1);
      move_pend_d = play && (move_tick || (move_pend && !move_commit));
      bul_pend_d  = play && (bul_tick  || (bul_pend  && !bul_commit));
      fire_req_d  = play && (fire_rise || (fire_req  && !fire_commit));

      // Joystick priority: up > down > left > right
      req_vld = i_up || i_down || i_left || i_right;
      if (i_up)        req_dir = DIR_UP;
      else if (i_down) req_dir = DIR_DOWN;
      else if (i_left) req_dir = DIR_LEFT;
      else             req_dir = DIR_RIGHT;

      // Pre-move neighbour: used both for the tank step and the spawn cell.
      tank_nxt = step_cell(tank_x, tank_y, tank_dir);
      bul_nxt  = step_cell(bul_x, bul_y, bul_dir);

      tank_x_d   = tank_x;
      tank_y_d   = tank_y;
      tank_dir_d = tank_dir;
      if (move_commit && req_vld) begin
         if (req_dir != tank_dir) begin
            tank_dir_d = req_dir;
         end else if (tank_nxt.ok) begin
            tank_x_d = tank_nxt.x;
            tank_y_d = tank_nxt.y;
         end
      end

      b_state_d = b_state;
      bul_x_d   = bul_x;
      bul_y_d   = bul_y;
      bul_dir_d = bul_dir;
      // A request landing while FLY, or with an off-grid spawn cell, is simply
      // consumed. A spawn also swallows a coincident bullet step.
      if (fire_commit && (b_state == B_IDLE) && tank_nxt.ok) begin
         b_state_d = B_FLY;
         bul_x_d   = tank_nxt.x;
         bul_y_d   = tank_nxt.y;
         bul_dir_d = tank_dir;
      end else if (bul_commit && (b_state == B_FLY)) begin
         if (bul_nxt.ok) begin
            bul_x_d = bul_nxt.x;
            bul_y_d = bul_nxt.y;
         end else begin
            b_state_d = B_IDLE;
         end
      end
   end

   assign o_tank_x       = tank_x;
   assign o_tank_y       = tank_y;
   assign o_tank_dir     = tank_dir;
   assign o_bullet_valid = (b_state == B_FLY);
   assign o_bullet_x     = bul_x;
   assign o_bullet_y     = bul_y;
   assign o_bullet_dir   = bul_dir;

endmodule

// File: tb/tb_tank_controller.sv
// -----------------------------------------------------------------------------
// tb_tank_controller
//   Directed vectors for tank_controller on an 8x8 grid, MOVE_DIV=4,
//   BULLET_DIV=2, start (2,2,up). Each vector holds its inputs for a number of
//   cycles and then compares every output. Leaving play for a cycle restarts
//   both dividers, so after re-entering play the k-th move shows after 4k+1
//   clocks and bullet steps show on clocks 3,5,7...
// -----------------------------------------------------------------------------
module tb_tank_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] i_top_state;
   logic       i_VGA_buzy, i_up, i_down, i_left, i_right, i_fire;
   logic [5:0] o_tank_x, o_tank_y, o_bullet_x, o_bullet_y;
   logic [1:0] o_tank_dir, o_bullet_dir;
   logic       o_bullet_valid;

   int checks   = 0;
   int failures = 0;

   localparam logic [1:0] P = 2'b01;
   localparam logic [1:0] N = 2'b00;

   tank_controller #(
      .GRID_W(8), .GRID_H(8), .INIT_X(2), .INIT_Y(2), .INIT_DIR(0),
      .MOVE_DIV(4), .BULLET_DIV(2), .PLAY_STATE(2'b01)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_top_state(i_top_state), .i_VGA_buzy(i_VGA_buzy),
      .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right), .i_fire(i_fire),
      .o_tank_x(o_tank_x), .o_tank_y(o_tank_y), .o_tank_dir(o_tank_dir),
      .o_bullet_valid(o_bullet_valid), .o_bullet_x(o_bullet_x), .o_bullet_y(o_bullet_y),
      .o_bullet_dir(o_bullet_dir)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] st;
      logic       bz, u, d, l, r, f;
      int         cyc;
      logic [5:0] tx, ty;
      logic [1:0] td;
      logic       bv;
      logic [5:0] bx, by;
      logic [1:0] bd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [1:0] st, input logic bz, u, d, l, r, f, input int cyc,
                      input logic [5:0] tx, ty, input logic [1:0] td,
                      input logic bv, input logic [5:0] bx, by, input logic [1:0] bd);
      vec_t v;
      v.st = st; v.bz = bz; v.u = u; v.d = d; v.l = l; v.r = r; v.f = f; v.cyc = cyc;
      v.tx = tx; v.ty = ty; v.td = td; v.bv = bv; v.bx = bx; v.by = by; v.bd = bd;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [1:0] st, input logic bz, u, d, l, r, f);
      i_top_state = st; i_VGA_buzy = bz;
      i_up = u; i_down = d; i_left = l; i_right = r; i_fire = f;
   endtask

   task automatic check(input string name, input logic [5:0] tx, ty, input logic [1:0] td,
                        input logic bv, input logic [5:0] bx, by, input logic [1:0] bd);
      checks++;
      if ({o_tank_x, o_tank_y, o_tank_dir, o_bullet_valid, o_bullet_x, o_bullet_y, o_bullet_dir}
          !== {tx, ty, td, bv, bx, by, bd}) begin
         failures++;
         $display("FAIL %s got tank=(%0d,%0d,%0d) bullet=%0b(%0d,%0d,%0d) want tank=(%0d,%0d,%0d) bullet=%0b(%0d,%0d,%0d)",
                  name, o_tank_x, o_tank_y, o_tank_dir, o_bullet_valid, o_bullet_x, o_bullet_y,
                  o_bullet_dir, tx, ty, td, bv, bx, by, bd);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(N, 0, 0, 0, 0, 0, 0);

      //   st bz u d l r f  cyc  tx ty td  bv bx by bd
      add(N, 0, 0,0,0,0,0,  2,  2,2,0,  0,0,0,0);   // reset state
      add(P, 0, 0,0,0,1,0,  4,  2,2,0,  0,0,0,0);   // no commit yet
      add(P, 0, 0,0,0,1,0,  1,  2,2,1,  0,0,0,0);   // first tick: turn only
      add(P, 0, 0,0,0,1,0,  4,  3,2,1,  0,0,0,0);   // second tick: step
      add(N, 0, 0,0,0,1,0, 10,  3,2,1,  0,0,0,0);   // out of play: frozen
      add(P, 0, 0,0,0,1,0, 17,  7,2,1,  0,0,0,0);   // four steps to right edge
      add(P, 0, 0,0,0,1,0,  8,  7,2,1,  0,0,0,0);   // clamp at x=7
      add(N, 0, 0,0,0,0,0,  1,  7,2,1,  0,0,0,0);
      add(P, 0, 0,1,0,0,0, 17,  7,5,2,  0,0,0,0);   // turn down, y 2->5
      add(N, 0, 0,0,0,0,0,  1,  7,5,2,  0,0,0,0);
      add(P, 0, 0,0,0,1,0,  5,  7,5,1,  0,0,0,0);   // turn right at (7,5)
      add(P, 0, 0,0,0,1,0,  8,  7,5,1,  0,0,0,0);   // clamp, no wrap
      add(N, 0, 0,0,0,0,0,  1,  7,5,1,  0,0,0,0);
      add(P, 0, 1,0,0,0,0, 17,  7,2,0,  0,0,0,0);   // turn up, y 5->2
      add(N, 0, 0,0,0,0,0,  1,  7,2,0,  0,0,0,0);
      add(P, 0, 1,0,1,0,0,  5,  7,1,0,  0,0,0,0);   // up beats left
      add(N, 0, 0,0,0,0,0,  1,  7,1,0,  0,0,0,0);
      add(P, 1, 0,1,0,0,0, 20,  7,1,0,  0,0,0,0);   // busy: nothing commits
      add(P, 0, 0,1,0,0,0,  1,  7,1,2,  0,0,0,0);   // one cycle after busy drops
      add(P, 0, 0,1,0,0,0,  3,  7,1,2,  0,0,0,0);   // pending did not stack
      add(P, 0, 0,1,0,0,0,  1,  7,2,2,  0,0,0,0);   // next regular tick
      add(N, 0, 0,0,0,0,0,  1,  7,2,2,  0,0,0,0);
      add(P, 0, 0,0,1,0,0, 25,  2,2,3,  0,0,0,0);   // turn left, x 7->2
      add(N, 0, 0,0,0,0,0,  1,  2,2,3,  0,0,0,0);
      add(P, 0, 0,0,0,1,0,  5,  2,2,1,  0,0,0,0);   // face right
      add(N, 0, 0,0,0,0,0,  1,  2,2,1,  0,0,0,0);
      add(P, 0, 0,0,0,0,1,  1,  2,2,1,  0,0,0,0);   // fire edge registered
      add(P, 0, 0,0,0,0,0,  1,  2,2,1,  1,3,2,1);   // spawn in front
      add(P, 0, 0,0,0,0,0,  1,  2,2,1,  1,4,2,1);   // first step
      add(P, 0, 0,0,0,0,1,  1,  2,2,1,  1,4,2,1);   // second pulse in flight
      add(P, 0, 0,0,0,0,1,  1,  2,2,1,  1,5,2,1);   // ignored, bullet steps
      add(P, 0, 0,0,0,0,0,  4,  2,2,1,  1,7,2,1);   // reaches x=7
      add(P, 0, 0,0,0,0,0,  2,  2,2,1,  0,7,2,1);   // leaves grid, pos held
      add(P, 0, 0,0,0,0,0,  4,  2,2,1,  0,7,2,1);   // no late spawn
      add(N, 0, 0,0,0,0,0,  1,  2,2,1,  0,7,2,1);
      add(P, 0, 0,1,0,0,0, 13,  2,4,2,  0,7,2,1);
      add(N, 0, 0,0,0,0,0,  1,  2,4,2,  0,7,2,1);
      add(P, 0, 0,0,1,0,0, 13,  0,4,3,  0,7,2,1);   // (0,4) facing left
      add(N, 0, 0,0,0,0,0,  1,  0,4,3,  0,7,2,1);
      add(P, 0, 0,0,0,0,1,  1,  0,4,3,  0,7,2,1);
      add(P, 0, 0,0,0,0,0,  4,  0,4,3,  0,7,2,1);   // off-grid spawn dropped
      add(N, 0, 0,0,0,0,0,  1,  0,4,3,  0,7,2,1);
      add(P, 0, 1,0,0,0,0,  5,  0,4,0,  0,7,2,1);   // face up
      add(N, 0, 0,0,0,0,0,  1,  0,4,0,  0,7,2,1);
      add(P, 0, 0,0,0,0,1,  1,  0,4,0,  0,7,2,1);
      add(P, 0, 0,0,0,0,0,  1,  0,4,0,  1,0,3,0);   // spawn upward
      add(N, 0, 0,0,0,0,0,  6,  0,4,0,  1,0,3,0);   // frozen mid-flight
      add(P, 0, 0,0,0,0,0,  2,  0,4,0,  1,0,3,0);
      add(P, 0, 0,0,0,0,0,  1,  0,4,0,  1,0,2,0);   // resumes

      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].st, vecs[i].bz, vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].r, vecs[i].f);
         repeat (vecs[i].cyc) @(negedge clk);
         check($sformatf("vec%0d", i), vecs[i].tx, vecs[i].ty, vecs[i].td,
               vecs[i].bv, vecs[i].bx, vecs[i].by, vecs[i].bd);
      end

      // Asynchronous reset while the bullet is flying
      drive(N, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      check("reset_async", 2, 2, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("reset_hold", 2, 2, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Fire request held through a busy stretch; spawn swallows the pending step
      drive(P, 1, 0, 0, 0, 0, 1);
      @(negedge clk);
      i_fire = 1'b0;
      repeat (5) @(negedge clk);
      check("fire_busy_wait", 2, 2, 0, 0, 0, 0, 0);
      i_VGA_buzy = 1'b0;
      @(negedge clk);
      check("fire_busy_spawn", 2, 2, 0, 1, 2, 1, 0);
      @(negedge clk);
      check("spawn_wins_step", 2, 2, 0, 1, 2, 1, 0);
      @(negedge clk);
      check("step_after_spawn", 2, 2, 0, 1, 2, 0, 0);
      repeat (2) @(negedge clk);
      check("top_edge_exit", 2, 2, 0, 0, 2, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
